// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_if : fetch-stage bundle (imem bus, redirect, decoder handoff)
// Rev 1.0
// ============================================================================
interface instr_fetch_if #(
  parameter int WIDTH = 32
) ();
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic             err_unexpected;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, err_unexpected,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, err_unexpected,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : credit-limited prefetcher with 2-entry {inst,pc} FIFO
// Rev 1.0
// ============================================================================
module instr_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
  input wire            clk,
  input wire            reset,
  instr_fetch_if.master bus
);

  localparam logic [WIDTH-1:0] c_STEP = WIDTH'(4);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [1:0]       r_out;
  logic [1:0]       r_disc;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_data [2];
  logic [WIDTH-1:0] r_pc   [2];
  logic             r_err;

  logic             w_rsp_ok;
  logic             w_pop;
  logic             w_req;
  logic             w_push;
  logic [1:0]       w_out_next;
  logic [1:0]       w_disc_next;
  logic [1:0]       w_slot;
  logic [WIDTH-1:0] w_rsp_pc;
  logic             w_unused_rpc_bits;

  assign w_rsp_ok   = bus.imem_rvalid && (r_out != 2'd0);
  assign w_pop      = (r_count != 2'd0) && bus.inst_ready;
  assign w_req      = (r_state == S_RUN) && !bus.redirect_valid &&
                      (({1'b0, r_count} + {1'b0, r_out}) < 3'd2);
  assign w_push     = w_rsp_ok && (r_disc == 2'd0) && !bus.redirect_valid;
  assign w_out_next = r_out + {1'b0, w_req} - {1'b0, w_rsp_ok};
  assign w_disc_next = bus.redirect_valid ? w_out_next :
                       ((w_rsp_ok && (r_disc != 2'd0)) ? (r_disc - 2'd1) : r_disc);
  assign w_slot     = r_count - {1'b0, w_pop};

  // With no discards pending, all in-flight requests are consecutive words
  // ending just below the fetch PC, so the oldest one is recovered by offset.
  assign w_rsp_pc   = r_fetch_pc - {{(WIDTH-4){1'b0}}, r_out, 2'b00};

  assign w_unused_rpc_bits = &{1'b0, bus.redirect_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_out      <= 2'd0;
      r_disc     <= 2'd0;
      r_count    <= 2'd0;
      r_err      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      r_out  <= w_out_next;
      r_disc <= w_disc_next;
      if (bus.imem_rvalid && (r_out == 2'd0)) begin
        r_err <= 1'b1;
      end
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + c_STEP;
      end

      if (bus.redirect_valid) begin
        r_fetch_pc <= {bus.redirect_pc[WIDTH-1:2], 2'b00};
        r_count    <= 2'd0;
        r_state    <= (w_disc_next != 2'd0) ? S_DRAIN : S_RUN;
      end else begin
        if (w_pop) begin
          r_data[0] <= r_data[1];
          r_pc[0]   <= r_pc[1];
        end
        // Later write wins: a push into slot 0 overrides the shift above.
        if (w_push) begin
          r_data[w_slot[0]] <= bus.imem_rdata;
          r_pc[w_slot[0]]   <= w_rsp_pc;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

        case (r_state)
          S_BOOT:  r_state <= S_RUN;
          S_DRAIN: if (w_disc_next == 2'd0) r_state <= S_RUN;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign bus.imem_req       = w_req;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.inst_valid     = (r_count != 2'd0);
  assign bus.inst           = (r_count != 2'd0) ? r_data[0] : NOP;
  assign bus.inst_pc        = (r_count != 2'd0) ? r_pc[0] : '0;
  assign bus.err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// tb_instr_fetch : directed and randomized checks of instr_fetch against a
// queue-based reference model and an in-order memory with random latency.
module tb_instr_fetch;
  localparam int          WIDTH = 32;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.WIDTH(WIDTH)) bus ();

  instr_fetch #(.WIDTH(WIDTH), .RESET_PC(32'h0), .NOP(NOP_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } entry_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  flight_t     m_fl[$];
  entry_t      m_fifo[$];
  pend_t       mem_q[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_err;

  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  logic [31:0] req_addr[$];
  int          req_cyc[$];
  logic [31:0] xfer_pc[$];
  int          first_valid_cyc;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(output bit e_req);
    bit stale_any;
    stale_any = 1'b0;
    foreach (m_fl[i]) if (m_fl[i].stale) stale_any = 1'b1;
    e_req = !m_boot && !bus.redirect_valid && !stale_any &&
            ((m_fifo.size() + m_fl.size()) < 2);
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("inst", bus.inst, m_fifo[0].data);
      chk("inst_pc", bus.inst_pc, m_fifo[0].pc);
    end else begin
      chk("inst_nop", bus.inst, NOP_W);
    end
    chk("err_unexpected", 32'(bus.err_unexpected), 32'(m_err));
  endtask

  task automatic model_update(input bit e_req);
    flight_t h;
    if (m_fifo.size() != 0 && bus.inst_ready) void'(m_fifo.pop_front());
    if (bus.imem_rvalid) begin
      if (m_fl.size() == 0) begin
        m_err = 1'b1;
      end else begin
        h = m_fl.pop_front();
        if (!h.stale && !bus.redirect_valid)
          m_fifo.push_back('{data: mem_word(h.addr), pc: h.addr});
      end
    end
    if (e_req) begin
      m_fl.push_back('{addr: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (bus.redirect_valid) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end
    m_boot = 1'b0;
  endtask

  task automatic drive_mem();
    pend_t p;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      p = mem_q.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(p.addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  endtask

  task automatic step();
    bit e_req;
    int lat;
    int due;
    @(negedge clk);
    check_cycle(e_req);
    if (bus.imem_req === 1'b1) begin
      req_addr.push_back(bus.imem_addr);
      req_cyc.push_back(cyc);
      lat = int'($urandom_range(lat_max, lat_min));
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: bus.imem_addr, due: due});
    end
    if (bus.inst_valid === 1'b1 && bus.inst_ready) xfer_pc.push_back(bus.inst_pc);
    if (bus.inst_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    @(posedge clk);
    model_update(e_req);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic clear_logs();
    req_addr.delete();
    req_cyc.delete();
    xfer_pc.delete();
  endtask

  // Asserts reset between edges, checks the immediate effect, holds it over
  // two edges with a stray response on the bus, then releases it.
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = $urandom;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    #2;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, NOP_W);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_err", 32'(bus.err_unexpected), 32'd0);
    m_fl.delete();
    m_fifo.delete();
    mem_q.delete();
    m_pc   = 32'h0;
    m_boot = 1'b1;
    m_err  = 1'b0;
    clear_logs();
    first_valid_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    last_due = -1;
    bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;
    lat_min = 1;
    lat_max = 1;
    #1;

    // Start-up with a one-cycle memory and an always-ready decoder.
    do_reset();
    repeat (8) step();
    chk("first_req_cycle", req_cyc[0], 1);
    chk("first_req_addr", req_addr[0], 32'h0);
    chk("first_valid_cycle", first_valid_cyc, 3);
    chk("order0", xfer_pc[0], 32'h0);
    chk("order1", xfer_pc[1], 32'h4);
    chk("order2", xfer_pc[2], 32'h8);

    // Decoder stalls: only two words may be in flight or buffered.
    do_reset();
    bus.inst_ready = 1'b0;
    repeat (12) step();
    chk("stall_req_count", req_addr.size(), 2);
    chk("stall_req0", req_addr[0], 32'h0);
    chk("stall_req1", req_addr[1], 32'h4);
    chk("stall_valid", 32'(bus.inst_valid), 32'd1);
    chk("stall_head_pc", bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    repeat (6) step();
    chk("release0", xfer_pc[0], 32'h0);
    chk("release1", xfer_pc[1], 32'h4);
    chk("release2", xfer_pc[2], 32'h8);

    // Redirect with two requests outstanding on a three-cycle memory.
    lat_min = 3;
    lat_max = 3;
    do_reset();
    repeat (3) step();
    chk("pre_redirect_reqs", req_addr.size(), 2);
    clear_logs();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    repeat (10) step();
    chk("drain_req_cycle", req_cyc[0], 6);
    chk("drain_req_addr", req_addr[0], 32'h100);
    chk("drain_first_pc", xfer_pc[0], 32'h100);

    // Redirect to an unaligned target in the same cycle as a response and a transfer.
    lat_min = 1;
    lat_max = 1;
    do_reset();
    repeat (3) step();
    clear_logs();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    step();
    bus.redirect_valid = 1'b0;
    repeat (6) step();
    chk("coinc_xfer0", xfer_pc[0], 32'h0);
    chk("coinc_xfer1", xfer_pc[1], 32'h200);
    chk("coinc_req_addr", req_addr[0], 32'h200);
    chk("coinc_req_cycle", req_cyc[0], 4);

    // Fetch address wraps past the top of the address space.
    do_reset();
    step();
    clear_logs();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    repeat (6) step();
    chk("wrap_req0", req_addr[0], 32'hFFFF_FFFC);
    chk("wrap_req1", req_addr[1], 32'h0000_0000);
    chk("wrap_xfer0", xfer_pc[0], 32'hFFFF_FFFC);
    chk("wrap_xfer1", xfer_pc[1], 32'h0000_0000);

    // Response with nothing outstanding.
    do_reset();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    chk("unexp_err", 32'(bus.err_unexpected), 32'd1);
    chk("unexp_valid", 32'(bus.inst_valid), 32'd0);
    repeat (5) step();
    chk("unexp_sticky", 32'(bus.err_unexpected), 32'd1);

    // Random traffic; each new round resets mid-operation.
    for (int r = 0; r < 6; r++) begin
      lat_min = 1;
      lat_max = 1 + (r % 4);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bus.inst_ready     = ($urandom_range(3, 0) != 0);
        bus.redirect_valid = ($urandom_range(11, 0) == 0);
        bus.redirect_pc    = $urandom;
        step();
      end
    end
    do_reset();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter WIDTH, default 32, instruction/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter NOP, default 32'h0000_0013 (addi x0,x0,0), value driven on inst when no instruction is valid.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request; the memory accepts it in the same cycle.
REQ-007 imem_addr  output  WIDTH  word-aligned fetch address, valid when imem_req=1.
REQ-008 imem_rvalid  input  1  response strobe; responses return in order, at least 1 cycle after their request.
REQ-009 imem_rdata  input  WIDTH  fetched instruction word, valid with imem_rvalid.
REQ-010 redirect_valid  input  1  control-flow change (branch/jump taken).
REQ-011 redirect_pc  input  WIDTH  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 inst  output  WIDTH  instruction presented to the decoder.
REQ-013 inst_pc  output  WIDTH  address of inst.
REQ-014 inst_valid  output  1  inst/inst_pc hold a live instruction.
REQ-015 inst_ready  input  1  downstream accepts; a transfer occurs when inst_valid && inst_ready.
REQ-016 err_unexpected  output  1  sticky flag; imem_rvalid arrived with zero outstanding requests.

Function
REQ-017 The block SHALL keep a 2-entry FIFO of {inst, pc}, a fetch PC register, a 2-bit outstanding counter and a 2-bit discard counter.
REQ-018 The block SHALL implement FSM states BOOT, RUN and DRAIN: BOOT->RUN after one cycle; RUN->DRAIN on redirect when the post-redirect discard count is nonzero; DRAIN->RUN on the cycle the discard count reaches 0.
REQ-019 In RUN, with redirect_valid=0 and (fifo_count + outstanding) < 2, the block SHALL assert imem_req with imem_addr = fetch PC; otherwise imem_req=0.
REQ-020 Each issued request SHALL increment the fetch PC by 4, modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
REQ-021 A response with discard count 0 SHALL push {imem_rdata, its request address} into the FIFO; a response with discard count > 0 SHALL be dropped and the discard count decremented.
REQ-022 Latency: imem_rvalid in cycle N SHALL give inst_valid=1 with that word in cycle N+1 when the FIFO was empty.
REQ-023 inst/inst_pc SHALL show the FIFO head; inst SHALL equal NOP and inst_valid SHALL be 0 when the FIFO is empty.
REQ-024 A transfer SHALL pop the FIFO head; a push and a pop in the same cycle SHALL both take effect.
REQ-025 On redirect_valid=1, at the next edge: FIFO cleared, fetch PC <= {redirect_pc[WIDTH-1:2],2'b00}, discard count <= outstanding minus any response arriving that cycle, and no request is issued that cycle.
REQ-026 A response arriving in the redirect cycle SHALL be dropped; a transfer in the redirect cycle SHALL count as completed.
REQ-027 A redirect while in DRAIN SHALL overwrite the fetch PC; the discard count continues to cover all outstanding responses.
REQ-028 The FIFO SHALL never overflow; the credit rule in REQ-019 guarantees it. An imem_rvalid with outstanding=0 SHALL be ignored and SHALL set err_unexpected.

Reset
REQ-029 reset=1 SHALL immediately force: state BOOT, fetch PC=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req=0, inst_valid=0, inst=NOP, inst_pc=0, err_unexpected=0.
REQ-030 Reset asserted mid-operation SHALL abandon in-flight requests; responses arriving while reset=1 SHALL be ignored.

Verification
REQ-031 Reset release, 1-cycle memory, inst_ready=1 -> first imem_req cycle 1 addr 0x0; inst_valid cycle 3 with inst_pc 0x0, then 0x4, 0x8 in order.
REQ-032 inst_ready=0 for 10 cycles -> exactly 2 requests issued (0x0, 0x4); inst_valid held with inst_pc=0x0; on release, 0x0 and 0x4 transfer with no loss or duplication.
REQ-033 Redirect to 0x100 with 2 requests outstanding (3-cycle memory) -> both stale responses dropped, state DRAIN then RUN; next delivered inst_pc=0x100.
REQ-034 Redirect to 0x203 coinciding with a response and a transfer -> response dropped, transfer completes, next fetch address 0x200.
REQ-035 Fetch PC at 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-036 imem_rvalid pulse right after reset with no request -> err_unexpected=1, sticky until reset; FIFO stays empty.
